// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decoded-instruction input channel and registered
// operand output channel of the ALU operand stage.
// master = the operand stage itself, slave = surrounding pipeline.
interface alu_operand_stage_if #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 6
);
  // input channel (decode -> operand stage)
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [ADDRESS_WIDTH-1:0] rs1_addr_i;
  logic [ADDRESS_WIDTH-1:0] rs2_addr_i;
  logic [DATA_WIDTH-1:0]    rs1_data_i;
  logic [DATA_WIDTH-1:0]    rs2_data_i;
  logic [DATA_WIDTH-1:0]    imm_i;
  logic                     use_imm_i;
  logic [3:0]               aluctrl_i;
  logic [ADDRESS_WIDTH-1:0] rd_addr_i;
  logic                     rd_wen_i;
  // output channel (operand stage -> ALU)
  logic                     out_ready_i;
  logic                     out_valid_o;
  logic [DATA_WIDTH-1:0]    alu_in1_o;
  logic [DATA_WIDTH-1:0]    alu_in2_o;
  logic [3:0]               aluctrl_o;
  logic [ADDRESS_WIDTH-1:0] rd_addr_o;
  logic                     rd_wen_o;

  modport master (
    input  in_valid_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i,
           imm_i, use_imm_i, aluctrl_i, rd_addr_i, rd_wen_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_in1_o, alu_in2_o, aluctrl_o,
           rd_addr_o, rd_wen_o
  );

  modport slave (
    output in_valid_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i,
           imm_i, use_imm_i, aluctrl_i, rd_addr_i, rd_wen_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_in1_o, alu_in2_o, aluctrl_o,
           rd_addr_o, rd_wen_o
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: selects ALU operands with EX/MEM and MEM/WB forwarding,
// stalls on load-use hazards and registers the result behind a valid/ready
// handshake with one cycle of latency.
// Optional: define OPERAND_STAGE_STALL_CNT_EN to enable the saturating
// load-use bubble counter on stall_cnt_o (tied to 0 otherwise).
module alu_operand_stage #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  alu_operand_stage_if.master      bus,
  input  logic                     exmem_wen_i,
  input  logic                     exmem_load_i,
  input  logic [ADDRESS_WIDTH-1:0] exmem_rd_i,
  input  logic [DATA_WIDTH-1:0]    exmem_data_i,
  input  logic                     memwb_wen_i,
  input  logic [ADDRESS_WIDTH-1:0] memwb_rd_i,
  input  logic [DATA_WIDTH-1:0]    memwb_data_i,
  input  logic                     flush_i,
  output logic [15:0]              stall_cnt_o
);

  logic                     hazard;
  logic                     accept;
  logic [DATA_WIDTH-1:0]    fwd1;
  logic [DATA_WIDTH-1:0]    fwd2;
  logic [DATA_WIDTH-1:0]    opb;

  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    alu_in1_q,   alu_in1_d;
  logic [DATA_WIDTH-1:0]    alu_in2_q,   alu_in2_d;
  logic [3:0]               aluctrl_q,   aluctrl_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q,   rd_addr_d;
  logic                     rd_wen_q,    rd_wen_d;

  // Load-use hazard: EX/MEM load result is needed but not yet available.
  always_comb begin
    hazard = exmem_wen_i & exmem_load_i &
             ((exmem_rd_i == bus.rs1_addr_i) |
              (!bus.use_imm_i & (exmem_rd_i == bus.rs2_addr_i)));
  end

  // The reset term only gates the visible ready; the flops are held in reset
  // anyway, so the internal accept does not need it.
  assign accept         = bus.in_valid_i & (!out_valid_q | bus.out_ready_i) & !hazard;
  assign bus.in_ready_o = (!out_valid_q | bus.out_ready_i) & !hazard & reset;

  // Operand selection: EX/MEM (non-load) beats MEM/WB beats register file.
  always_comb begin
    fwd1 = bus.rs1_data_i;
    if (exmem_wen_i & !exmem_load_i & (exmem_rd_i == bus.rs1_addr_i))
      fwd1 = exmem_data_i;
    else if (memwb_wen_i & (memwb_rd_i == bus.rs1_addr_i))
      fwd1 = memwb_data_i;

    fwd2 = bus.rs2_data_i;
    if (exmem_wen_i & !exmem_load_i & (exmem_rd_i == bus.rs2_addr_i))
      fwd2 = exmem_data_i;
    else if (memwb_wen_i & (memwb_rd_i == bus.rs2_addr_i))
      fwd2 = memwb_data_i;

    opb = bus.use_imm_i ? bus.imm_i : fwd2;
  end

  // Output register next state: flush, then accept, then drain to a bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    aluctrl_d   = aluctrl_q;
    rd_addr_d   = rd_addr_q;
    rd_wen_d    = rd_wen_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      rd_wen_d    = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_in1_d   = fwd1;
      alu_in2_d   = opb;
      aluctrl_d   = bus.aluctrl_i;
      rd_addr_d   = bus.rd_addr_i;
      rd_wen_d    = bus.rd_wen_i;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
      rd_wen_d    = 1'b0;
    end
  end

  // Output register; asynchronous reset drops any held instruction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      aluctrl_q   <= '0;
      rd_addr_q   <= '0;
      rd_wen_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      aluctrl_q   <= aluctrl_d;
      rd_addr_q   <= rd_addr_d;
      rd_wen_q    <= rd_wen_d;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.alu_in1_o   = alu_in1_q;
  assign bus.alu_in2_o   = alu_in2_q;
  assign bus.aluctrl_o   = aluctrl_q;
  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.rd_wen_o    = rd_wen_q;

`ifdef OPERAND_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Count cycles where a presented instruction is blocked by a load-use hazard.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cnt_q <= '0;
    else if (bus.in_valid_i & hazard & (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: randomized and directed stimulus for the ALU operand
// stage; a driver predicts each accepted instruction into a queue and a
// monitor checks the registered outputs against it every cycle.
module tb_alu_operand_stage;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          exmem_wen_i, exmem_load_i, memwb_wen_i, flush_i;
  logic [AW-1:0] exmem_rd_i, memwb_rd_i;
  logic [DW-1:0] exmem_data_i, memwb_data_i;
  logic [15:0]   stall_cnt_o;

  always #5 clock = ~clock;

  alu_operand_stage_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  alu_operand_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .exmem_wen_i  (exmem_wen_i),
    .exmem_load_i (exmem_load_i),
    .exmem_rd_i   (exmem_rd_i),
    .exmem_data_i (exmem_data_i),
    .memwb_wen_i  (memwb_wen_i),
    .memwb_rd_i   (memwb_rd_i),
    .memwb_data_i (memwb_data_i),
    .flush_i      (flush_i),
    .stall_cnt_o  (stall_cnt_o)
  );

  typedef struct {
    logic          in_valid;
    logic [AW-1:0] rs1, rs2, rd, ex_rd, mw_rd;
    logic [DW-1:0] d1, d2, imm, ex_data, mw_data;
    logic          use_imm, wen, ex_wen, ex_load, mw_wen, flush, out_ready;
    logic [3:0]    ctrl;
  } stim_t;

  typedef struct {
    logic [DW-1:0] a, b;
    logic [3:0]    ctrl;
    logic [AW-1:0] rd;
    logic          wen;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cnt_m   = 0;
  bit          mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t base();
    stim_t s;
    s = '{in_valid: 1'b0, rs1: '0, rs2: '0, rd: '0, ex_rd: '0, mw_rd: '0,
          d1: '0, d2: '0, imm: '0, ex_data: '0, mw_data: '0,
          use_imm: 1'b0, wen: 1'b0, ex_wen: 1'b0, ex_load: 1'b0, mw_wen: 1'b0,
          flush: 1'b0, out_ready: 1'b1, ctrl: '0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s           = base();
    s.in_valid  = ($urandom_range(0, 3) != 0);
    s.rs1       = AW'($urandom_range(0, 7));
    s.rs2       = AW'($urandom_range(0, 7));
    s.rd        = AW'($urandom_range(0, 63));
    s.ex_rd     = AW'($urandom_range(0, 7));
    s.mw_rd     = AW'($urandom_range(0, 7));
    s.d1        = {$urandom, $urandom};
    s.d2        = {$urandom, $urandom};
    s.imm       = {$urandom, $urandom};
    s.ex_data   = {$urandom, $urandom};
    s.mw_data   = {$urandom, $urandom};
    s.use_imm   = $urandom_range(0, 1) == 1;
    s.wen       = $urandom_range(0, 1) == 1;
    s.ex_wen    = $urandom_range(0, 1) == 1;
    s.ex_load   = ($urandom_range(0, 9) < 3);
    s.mw_wen    = $urandom_range(0, 1) == 1;
    s.flush     = ($urandom_range(0, 15) == 0);
    s.out_ready = ($urandom_range(0, 9) < 7);
    s.ctrl      = 4'($urandom_range(0, 15));
    return s;
  endfunction

  // Value the instruction should see for a source register.
  function automatic logic [DW-1:0] source_value(input stim_t s, input logic [AW-1:0] r,
                                                  input logic [DW-1:0] rf);
    if (s.ex_wen && !s.ex_load && s.ex_rd == r) return s.ex_data;
    if (s.mw_wen && s.mw_rd == r)               return s.mw_data;
    return rf;
  endfunction

  function automatic bit load_use(input stim_t s);
    return s.ex_wen && s.ex_load && (s.ex_rd == s.rs1 || (!s.use_imm && s.ex_rd == s.rs2));
  endfunction

  task automatic apply(input stim_t s);
    bus.in_valid_i  = s.in_valid;
    bus.rs1_addr_i  = s.rs1;
    bus.rs2_addr_i  = s.rs2;
    bus.rs1_data_i  = s.d1;
    bus.rs2_data_i  = s.d2;
    bus.imm_i       = s.imm;
    bus.use_imm_i   = s.use_imm;
    bus.aluctrl_i   = s.ctrl;
    bus.rd_addr_i   = s.rd;
    bus.rd_wen_i    = s.wen;
    bus.out_ready_i = s.out_ready;
    exmem_wen_i     = s.ex_wen;
    exmem_load_i    = s.ex_load;
    exmem_rd_i      = s.ex_rd;
    exmem_data_i    = s.ex_data;
    memwb_wen_i     = s.mw_wen;
    memwb_rd_i      = s.mw_rd;
    memwb_data_i    = s.mw_data;
    flush_i         = s.flush;
  endtask

  // Present one cycle of inputs (called just after a rising edge); predict.
  task automatic body(input stim_t s);
    bit   hz, rdy;
    exp_t e;
    apply(s);
    #1;
    hz  = load_use(s);
    rdy = (q.size() == 0 || s.out_ready) && !hz;
    chk("in_ready", bus.in_ready_o, rdy);
    e.a    = source_value(s, s.rs1, s.d1);
    e.b    = s.use_imm ? s.imm : source_value(s, s.rs2, s.d2);
    e.ctrl = s.ctrl;
    e.rd   = s.rd;
    e.wen  = s.wen;
    @(negedge clock);
    #1;
`ifdef OPERAND_STAGE_STALL_CNT_EN
    if (s.in_valid && hz && cnt_m < 16'hFFFF) cnt_m++;
`endif
    if (s.in_valid && rdy && !s.flush) q.push_back(e);
  endtask

  task automatic cycle(input stim_t s);
    @(posedge clock);
    #1;
    body(s);
  endtask

  // Assert reset for one cycle, check cleared state, release with s presented.
  task automatic do_reset(input stim_t s);
    @(posedge clock);
    #1;
    mon_en = 1'b0;
    reset  = 1'b0;
    apply(s);
    #1;
    chk("rst_out_valid", bus.out_valid_o, '0);
    chk("rst_rd_wen",    bus.rd_wen_o,    '0);
    chk("rst_alu_in1",   bus.alu_in1_o,   '0);
    chk("rst_alu_in2",   bus.alu_in2_o,   '0);
    chk("rst_aluctrl",   bus.aluctrl_o,   '0);
    chk("rst_rd_addr",   bus.rd_addr_o,   '0);
    chk("rst_stall_cnt", stall_cnt_o,     '0);
    chk("rst_in_ready",  bus.in_ready_o,  '0);
    q.delete();
    cnt_m = 0;
    @(posedge clock);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    body(s);
  endtask

  // Monitor: compare the registered outputs against the expected front entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("out_valid", bus.out_valid_o, q.size() != 0);
        if (q.size() == 0) begin
          chk("bubble_rd_wen", bus.rd_wen_o, '0);
        end else begin
          e = q[0];
          chk("alu_in1", bus.alu_in1_o, e.a);
          chk("alu_in2", bus.alu_in2_o, e.b);
          chk("aluctrl", bus.aluctrl_o, e.ctrl);
          chk("rd_addr", bus.rd_addr_o, e.rd);
          chk("rd_wen",  bus.rd_wen_o,  e.wen);
          if (bus.out_ready_i || flush_i) void'(q.pop_front());
        end
        chk("stall_cnt", stall_cnt_o, cnt_m);
      end
    end
  end

  initial begin
    stim_t s, a;
    reset = 1'b1;
    apply(base());
    #1 reset = 1'b0;

    // Plain accept: rs1 from register file, operand B from immediate.
    s = base();
    s.in_valid = 1'b1; s.rs1 = 3; s.d1 = 10; s.imm = 5; s.use_imm = 1'b1;
    s.ctrl = 4'hA; s.rd = 7; s.wen = 1'b1;
    do_reset(s);
    cycle(base());

    // Forwarding: EX/MEM wins over MEM/WB, then MEM/WB when EX/MEM idle.
    s = base();
    s.in_valid = 1'b1; s.rs1 = 3; s.d1 = 10; s.rs2 = 3; s.d2 = 11;
    s.ex_wen = 1'b1; s.ex_rd = 3; s.ex_data = 99;
    s.mw_wen = 1'b1; s.mw_rd = 3; s.mw_data = 77; s.rd = 1; s.wen = 1'b1;
    cycle(s);
    s.ex_wen = 1'b0;
    cycle(s);
    cycle(base());

    // Load-use on rs2 with register operand B: stall and bubble.
    s = base();
    s.in_valid = 1'b1; s.rs1 = 1; s.rs2 = 4; s.use_imm = 1'b0;
    s.ex_wen = 1'b1; s.ex_load = 1'b1; s.ex_rd = 4; s.rd = 2; s.wen = 1'b1;
    cycle(s);
    cycle(base());

    // Backpressure for three cycles, then release.
    a = base();
    a.in_valid = 1'b1; a.rs1 = 5; a.d1 = 64'h1234; a.imm = 64'hFFFF_FFFF_FFFF_FFF0;
    a.use_imm = 1'b1; a.ctrl = 4'h3; a.rd = 9; a.wen = 1'b1;
    cycle(a);
    s = a; s.d1 = 64'h5555; s.rd = 10; s.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(s);
    s.out_ready = 1'b1;
    cycle(s);
    cycle(base());

    // Flush with a held valid output and a would-be accept.
    cycle(a);
    s = a; s.out_ready = 1'b0; s.rd = 11;
    cycle(s);
    s.out_ready = 1'b1; s.flush = 1'b1;
    cycle(s);
    cycle(base());

    // Reset while holding a stalled output: held instruction is lost.
    cycle(a);
    s = a; s.out_ready = 1'b0;
    cycle(s);
    cycle(s);
    s = a; s.rd = 12; s.d1 = 64'hABCD;
    do_reset(s);
    cycle(base());

    // Randomized traffic.
    for (int i = 0; i < 400; i++) cycle(rnd());

    for (int i = 0; i < 3; i++) cycle(base());
    chk("drain", q.size(), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
